seq_cplx_mult: RTL and testbench

//  Multi-cycle signed complex multiplier: (ar + j*ai) * (br + j*bi), with an optional
//  per-transaction conjugate of the b operand.
//  A single shared NxM signed multiplier is time-shared over 4 steps, replacing a parallel

---
 rtl/seq_cplx_mult.sv | 162 ++++++++++++++++
 tb/tb_seq_cplx_mult.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_cplx_mult.sv
// seq_cplx_mult
//   Signed complex multiplier (ar + j*ai) * (br + j*bi), optionally using conj(b).
//   A single shared NxM signed multiplier is used over four consecutive cycles.
//   Operands are taken on a valid/ready handshake, and the result is held until
//   the downstream side accepts it.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | ready for operands (in_ready=1)
//   CALC  | one partial product per cycle, step 0..3
//   DONE  | result presented (out_valid=1), waiting for out_ready
//
//   step | multiplier operands | accumulator update
//   -----+---------------------+--------------------------------------------
//   0    | ar * br             | acc_r  = p
//   1    | ai * bi             | acc_r -= p   (conj: acc_r += p)
//   2    | ar * bi             | acc_i  = p   (conj: acc_i  = -p)
//   3    | ai * br             | acc_i += p

module seq_cplx_mult #(
    parameter int N = 12,
    parameter int M = 13,
    localparam int Q = N + M + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                conj_b,
    input  logic signed [N-1:0] ar,
    input  logic signed [N-1:0] ai,
    input  logic signed [M-1:0] br,
    input  logic signed [M-1:0] bi,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [Q-1:0] pr,
    output logic signed [Q-1:0] pi
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] STEP_LAST = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [1:0]          step;

    logic signed [N-1:0] ar_q;
    logic signed [N-1:0] ai_q;
    logic signed [M-1:0] br_q;
    logic signed [M-1:0] bi_q;
    logic                conj_q;

    logic signed [Q-1:0] acc_r;
    logic signed [Q-1:0] acc_i;

    logic signed [N-1:0]   mul_a;
    logic signed [M-1:0]   mul_b;
    logic signed [N+M-1:0] prod;
    logic signed [Q-1:0]   prod_ext;

    logic accept;
    logic release_out;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;

    // The accumulators are the result registers. They only change in CALC,
    // so pr/pi remain stable for the whole DONE phase.
    assign pr = acc_r;
    assign pi = acc_i;

    // Select the operand pair for the shared multiplier from the current step
    always_comb begin
        mul_a = ar_q;
        mul_b = br_q;
        case (step)
            2'd0: begin mul_a = ar_q; mul_b = br_q; end
            2'd1: begin mul_a = ai_q; mul_b = bi_q; end
            2'd2: begin mul_a = ar_q; mul_b = bi_q; end
            default: begin mul_a = ai_q; mul_b = br_q; end
        endcase
    end

    // Shared signed multiplier. The product is sign-extended by one bit, which
    // guarantees that the sum of two products cannot wrap.
    always_comb begin
        prod     = mul_a * mul_b;
        prod_ext = {prod[N+M-1], prod};
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)            state_nxt = CALC;
            CALC: if (step == STEP_LAST) state_nxt = DONE;
            DONE: if (release_out)       state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // State register. A reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step counter. It restarts at 0 on every accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step <= 2'd0;
        end else if (accept) begin
            step <= 2'd0;
        end else if (state == CALC) begin
            step <= step + 2'd1;
        end
    end

    // Capture the operands at accept, so later changes at the inputs are ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_q   <= '0;
            ai_q   <= '0;
            br_q   <= '0;
            bi_q   <= '0;
            conj_q <= 1'b0;
        end else if (accept) begin
            ar_q   <= ar;
            ai_q   <= ai;
            br_q   <= br;
            bi_q   <= bi;
            conj_q <= conj_b;
        end
    end

    // Accumulate the real and imaginary parts, one partial product per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= '0;
            acc_i <= '0;
        end else if (accept) begin
            acc_r <= '0;
            acc_i <= '0;
        end else if (state == CALC) begin
            case (step)
                2'd0: acc_r <= prod_ext;
                2'd1: acc_r <= conj_q ? (acc_r + prod_ext) : (acc_r - prod_ext);
                2'd2: acc_i <= conj_q ? (-prod_ext) : prod_ext;
                default: acc_i <= acc_i + prod_ext;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_cplx_mult.sv
// tb_seq_cplx_mult
//   Directed vectors with hand-computed results for seq_cplx_mult (N=12, M=13).

module tb_seq_cplx_mult;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               conj_b;
    logic signed [11:0] ar;
    logic signed [11:0] ai;
    logic signed [12:0] br;
    logic signed [12:0] bi;
    logic               out_valid;
    logic               out_ready;
    logic signed [25:0] pr;
    logic signed [25:0] pi;

    int checks;
    int failures;

    typedef struct {
        logic signed [11:0] ar;
        logic signed [11:0] ai;
        logic signed [12:0] br;
        logic signed [12:0] bi;
        logic               conj;
        logic signed [25:0] pr;
        logic signed [25:0] pi;
    } vec_t;

    vec_t vecs[7];

    seq_cplx_mult #(.N(12), .M(13)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .conj_b    (conj_b),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pr        (pr),
        .pi        (pi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one transaction. Returns the number of cycles from accept to out_valid
    // in lat. The inputs are scrambled after accept to show that they were latched.
    task automatic start_and_wait(input vec_t v, output int lat);
        int w;
        ar       = v.ar;
        ai       = v.ai;
        br       = v.br;
        bi       = v.bi;
        conj_b   = v.conj;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        ar       = 12'sh5a5;
        ai       = -12'sd77;
        br       = 13'sh0f0f;
        bi       = 13'sd999;
        conj_b   = ~v.conj;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        start_and_wait(v, lat);
        check({tag, "_latency"}, lat, 4);
        check({tag, "_pr"}, pr, v.pr);
        check({tag, "_pi"}, pi, v.pi);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        int hi_cycles;
        int stable_bad;
        logic signed [25:0] hold_pr;
        logic signed [25:0] hold_pi;

        checks   = 0;
        failures = 0;

        //          ar     ai     br     bi     conj  pr         pi
        vecs[0] = '{12'sd3,  12'sd4,  13'sd5,  13'sd6,  1'b0, -26'sd9,    26'sd38};
        vecs[1] = '{12'sd3,  12'sd4,  13'sd5,  13'sd6,  1'b1, 26'sd39,    26'sd2};
        vecs[2] = '{-12'sd2048, -12'sd2048, -13'sd4096, -13'sd4096, 1'b0, 26'sd0, 26'sd16777216};
        vecs[3] = '{-12'sd2048, -12'sd2048, -13'sd4096, -13'sd4096, 1'b1, 26'sd16777216, 26'sd0};
        vecs[4] = '{-12'sd2048, 12'sd2047, 13'sd4095, -13'sd4096, 1'b0, -26'sd2048, 26'sd16771073};
        vecs[5] = '{12'sd1,  12'sd1,  13'sd1, -13'sd1,  1'b0, 26'sd2,     26'sd0};
        vecs[6] = '{-12'sd7, 12'sd11, 13'sd13, -13'sd5, 1'b1, -26'sd146,  26'sd108};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        conj_b    = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0;

        // Reset
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_pr", pr, 0);
        check("rst_pi", pi, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, in_ready low, new operands ignored
        start_and_wait(vecs[0], lat);
        check("bp_latency", lat, 4);
        hold_pr = pr;
        hold_pi = pi;
        in_valid = 1'b1;
        ar = 12'sd100; ai = 12'sd100; br = 13'sd100; bi = 13'sd100;
        stable_bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (pr !== hold_pr || pi !== hold_pi || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable_bad++;
        end
        check("bp_stable_cycles_bad", stable_bad, 0);
        check("bp_pr", pr, -9);
        check("bp_pi", pi, 38);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_no_stray_accept", in_ready, 1);

        // out_ready held high throughout: result valid for exactly one cycle
        out_ready = 1'b1;
        start_and_wait(vecs[6], lat);
        check("cont_latency", lat, 4);
        check("cont_pr", pr, -146);
        check("cont_pi", pi, 108);
        hi_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) hi_cycles++;
            tick();
        end
        check("cont_valid_cycles", hi_cycles, 1);
        out_ready = 1'b0;

        // Reset during step 2 discards the transaction
        ar = 12'sd3; ai = 12'sd4; br = 13'sd5; bi = 13'sd6; conj_b = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_pr", pr, 0);
        check("midrst_pi", pi, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_idle_stays", out_valid, 0);
        run_vec(vecs[5], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
